// File: rtl/uart_rcv.sv
// 8N1 UART receiver: 2-flop RX synchronizer, mid-bit sampling, rdy/clr_rdy handshake.
// Optional UART_FRAMING_ERR_EN adds a framing_err output that flags a low stop bit.
module uart_rcv #(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data
`ifdef UART_FRAMING_ERR_EN
  ,
  output logic       framing_err
`endif
);

  localparam int CW = $clog2(BAUD_CNT + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_CNT >> 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_CNT);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [8:0]      shreg;
  logic            start;
  logic            tick;
  logic            done;

  // Preset to idle level so reset release never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!rx_s) state_nx = RECV;
      RECV: begin
        if (tick) begin
          if (bit_cnt == 4'd0 && rx_s) state_nx = IDLE;
          else if (bit_cnt == 4'd9)    state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    tick  = 1'b0;
    done  = 1'b0;
    unique case (state)
      IDLE:    start = !rx_s;
      RECV:    tick  = (baud_cnt == '0);
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (start) begin
      baud_cnt <= HALF;
      bit_cnt  <= '0;
    end else if (tick) begin
      baud_cnt <= FULL;
      bit_cnt  <= bit_cnt + 4'd1;
      shreg    <= {rx_s, shreg[8:1]};
    end else if (state == RECV) begin
      baud_cnt <= baud_cnt - 1'b1;
    end
  end

  // Start bit has been shifted out; shreg[8] holds stop, [7:0] the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy     <= 1'b0;
      rx_data <= 8'h00;
    end else begin
      if (done) begin
        rdy     <= 1'b1;
        rx_data <= shreg[7:0];
      end else if (start || clr_rdy) begin
        rdy     <= 1'b0;
      end
    end
  end

`ifdef UART_FRAMING_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       framing_err <= 1'b0;
    else if (done) framing_err <= ~shreg[8];
  end
`endif

endmodule

// File: tb/tb_uart_rcv.sv
// Directed/random bench for uart_rcv with a reduced bit period.
// Expected bytes come from the transmitted values; timing from the bit-period rules.
module tb_uart_rcv;
  localparam int B = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic       rdy;
  logic [7:0] rx_data;
`ifdef UART_FRAMING_ERR_EN
  logic       framing_err;
`endif

  logic tie;
  logic clr_man;
  assign clr_rdy = tie ? rdy : clr_man;

  uart_rcv #(.BAUD_CNT(B)) dut (
    .clk(clk),
    .rst(rst),
    .RX(RX),
    .clr_rdy(clr_rdy),
    .rdy(rdy),
    .rx_data(rx_data)
`ifdef UART_FRAMING_ERR_EN
    ,
    .framing_err(framing_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned rise_cyc = 0;
  int high_cycles = 0;
  int rises = 0;
  logic rdy_q = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy && !rdy_q) begin
      rise_cyc = cyc;
      rises++;
    end
    if (rdy) begin
      high_cycles++;
      if (tie) got.push_back(rx_data);
    end
    rdy_q = rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    RX = v;
    repeat (B) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(stop);
  endtask

  initial begin
    int lat;
    int hc0;
    int r0;
    logic [7:0] r;
    logic [7:0] prev;
    logic [7:0] partial;

    rst = 1'b1;
    RX = 1'b1;
    tie = 1'b0;
    clr_man = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_rdy", rdy, 0);
    check("reset_data", rx_data, 8'h00);

    idle(20000);
    check("idle_rdy", rdy, 0);
    check("idle_data", rx_data, 8'h00);
    check("idle_rises", rises, 0);

    // Single frame, no clear: rdy must rise near mid stop bit and hold
    send(8'hA5, 1'b1);
    lat = int'(rise_cyc - start_cyc);
    check("a5_rdy", rdy, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_latency", (lat >= (19 * B) / 2 + 2 - B / 4) &&
                        (lat <= (19 * B) / 2 + 2 + B / 4), 1);
    idle(5 * B);
    check("a5_hold", rdy, 1);
    clr_man = 1'b1;
    idle(1);
    clr_man = 1'b0;
    check("clr_rdy", rdy, 0);
    check("clr_data", rx_data, 8'hA5);

    // Back-to-back frames with clr_rdy tied to rdy: one-cycle pulses
    tie = 1'b1;
    got.delete();
    exp_q.delete();
    hc0 = high_cycles;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) send(exp_q[i], 1'b1);
    idle(2 * B);
    check("b2b_count", got.size(), exp_q.size());
    check("b2b_pulse_cycles", high_cycles - hc0, exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got.size()) check($sformatf("b2b_byte%0d", i), got[i], exp_q[i]);
    end
    check("b2b_last_data", rx_data, exp_q[exp_q.size() - 1]);
    tie = 1'b0;

    // Short low glitch shorter than half a bit must be rejected
    prev = rx_data;
    r0 = rises;
    RX = 1'b0;
    idle(B / 4);
    RX = 1'b1;
    idle(2 * B);
    check("glitch_rdy", rdy, 0);
    check("glitch_rises", rises - r0, 0);
    check("glitch_data", rx_data, prev);
    r = 8'($urandom);
    send(r, 1'b1);
    check("post_glitch_rdy", rdy, 1);
    check("post_glitch_data", rx_data, r);

    // Reset in the middle of a frame discards it
    partial = 8'h3C;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(partial[i]);
    rst = 1'b1;
    #1;
    check("midrst_rdy", rdy, 0);
    check("midrst_data", rx_data, 8'h00);
    RX = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(B);
    r0 = rises;
    send(8'h5A, 1'b1);
    idle(B);
    check("after_rst_rises", rises - r0, 1);
    check("after_rst_rdy", rdy, 1);
    check("after_rst_data", rx_data, 8'h5A);

    // Low stop bit: byte still delivered
    clr_man = 1'b1;
    idle(1);
    clr_man = 1'b0;
    r0 = rises;
    send(8'h81, 1'b0);
    RX = 1'b1;
    idle(3 * B);
    check("badstop_rises", rises - r0, 1);
    check("badstop_data", rx_data, 8'h81);
`ifdef UART_FRAMING_ERR_EN
    check("badstop_ferr", framing_err, 1);
`endif
    r = 8'($urandom);
    send(r, 1'b1);
    check("goodstop_rdy", rdy, 1);
    check("goodstop_data", rx_data, r);
`ifdef UART_FRAMING_ERR_EN
    check("goodstop_ferr", framing_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
